// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants for the FIFO pop adapter
package fifo_pkg;

  // Two entries is the minimum depth that covers the one-cycle FIFO read
  // latency and still streams one beat per cycle.
  localparam int BUF_DEPTH      = 2;
  localparam int BEAT_CNT_WIDTH = 16;
  // Occupancy counter width: holds 0..BUF_DEPTH.
  localparam int CNT_W          = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry in-order buffer with write port, head read and pop
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset (clears data too)
//   wr_en, wr_data   append wr_data at the tail
//   rd_en            drop the head entry
//   head_data        oldest entry (zero when reset and empty)
//   count            number of valid entries, 0..BUF_DEPTH
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  // One-bit pointers: the storage is exactly two entries deep.
  logic                  rd_ptr;
  logic                  wr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      // Simultaneous write and read leaves the occupancy unchanged.
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_en && !rd_en && count == CNT_W'(BUF_DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(rd_en && count == '0));

endmodule

// File: rtl/fifo_pop_adapter.sv
// rtl/fifo_pop_adapter.sv - turns a registered-read FIFO into a valid/ready stream
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable_i          permits new pops
//   fifo_empty_i      FIFO empty flag
//   fifo_rd_data_i    FIFO read data, valid the cycle after an accepted pop
//   fifo_pop_o        pop request to the FIFO (combinational)
//   m_valid_o/m_ready_i/m_data_o   output stream
//   beat_count_o      delivered beats, wraps modulo 2^16
//   idle_o            buffer empty and no pop in flight
module fifo_pop_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable_i,
  input  logic                      fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data_i,
  output logic                      fifo_pop_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [DATA_WIDTH-1:0]     m_data_o,
  output logic [BEAT_CNT_WIDTH-1:0] beat_count_o,
  output logic                      idle_o
);

  logic [CNT_W-1:0]          buf_count;
  logic                      inflight;
  logic                      transfer;
  logic [CNT_W:0]            level;
  logic [BEAT_CNT_WIDTH-1:0] beat_count_q;

  assign m_valid_o = (buf_count != '0);
  assign transfer  = m_valid_o && m_ready_i;

  // Projected occupancy at the next edge, counting the pop already in
  // flight and crediting a beat leaving this cycle. transfer implies
  // buf_count >= 1, so the subtraction cannot wrap.
  assign level = {1'b0, buf_count}
               + {{CNT_W{1'b0}}, inflight}
               - {{CNT_W{1'b0}}, transfer};

  // Gated by reset_n so no pop is requested while the FIFO is in reset.
  assign fifo_pop_o = reset_n && enable_i && !fifo_empty_i
                   && (level < (CNT_W + 1)'(BUF_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= 1'b0;
      beat_count_q <= '0;
    end else begin
      inflight <= fifo_pop_o;
      if (transfer) beat_count_q <= beat_count_q + BEAT_CNT_WIDTH'(1);
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (inflight),
    .wr_data   (fifo_rd_data_i),
    .rd_en     (transfer),
    .head_data (m_data_o),
    .count     (buf_count)
  );

  assign beat_count_o = beat_count_q;
  assign idle_o       = (buf_count == '0) && !inflight;

endmodule
